scroll_msg_arbiter: RTL

//  Shares the single 8-char scrolling display window among ATM message sources (balance, deposit,

---
 rtl/scroll_msg_pkg.sv | 63 ++++++
 rtl/scroll_msg_arbiter_rom.sv | 22 ++
 rtl/scroll_msg_arbiter.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/scroll_msg_pkg.sv
// Shared constants, state encoding and the fixed ATM message table.
package scroll_msg_pkg;

    localparam int CHAR_W    = 5;
    localparam int MSG_NUM   = 4;
    localparam int MSG_ID_W  = 2;
    localparam int MSG_MAX   = 16;
    localparam int MSG_IDX_W = 4;

    localparam logic [CHAR_W-1:0] CH_BLANK = 5'd0;
    localparam logic [CHAR_W-1:0] CH_A = 5'd1,  CH_B = 5'd2,  CH_C = 5'd3,  CH_D = 5'd4;
    localparam logic [CHAR_W-1:0] CH_E = 5'd5,  CH_F = 5'd6,  CH_G = 5'd7,  CH_H = 5'd8;
    localparam logic [CHAR_W-1:0] CH_I = 5'd9,  CH_J = 5'd10, CH_K = 5'd11, CH_L = 5'd12;
    localparam logic [CHAR_W-1:0] CH_M = 5'd13, CH_N = 5'd14, CH_O = 5'd15, CH_P = 5'd16;
    localparam logic [CHAR_W-1:0] CH_Q = 5'd17, CH_R = 5'd18, CH_S = 5'd19, CH_T = 5'd20;
    localparam logic [CHAR_W-1:0] CH_U = 5'd21, CH_V = 5'd22, CH_W = 5'd23, CH_X = 5'd24;
    localparam logic [CHAR_W-1:0] CH_Y = 5'd25, CH_Z = 5'd26;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_PAD,
        ST_DONE
    } state_e;

    // Message text is stored left-justified as ASCII; the first char sits in the top byte.
    localparam logic [8*MSG_MAX-1:0] MSG_TXT0 = {"SHOW BALANCE", 32'h0};
    localparam logic [8*MSG_MAX-1:0] MSG_TXT1 = {"DEPOSIT", 72'h0};
    localparam logic [8*MSG_MAX-1:0] MSG_TXT2 = {"WITHDRAW", 64'h0};
    localparam logic [8*MSG_MAX-1:0] MSG_TXT3 = {"ERROR", 88'h0};

    function automatic int msg_len(input logic [MSG_ID_W-1:0] id);
        int len;
        case (id)
            2'd0:    len = 12;
            2'd1:    len = 7;
            2'd2:    len = 8;
            default: len = 5;
        endcase
        return len;
    endfunction

    // Any non-letter (space, padding) maps to the blank code.
    function automatic logic [CHAR_W-1:0] msg_char(input logic [MSG_ID_W-1:0] id,
                                                   input logic [MSG_IDX_W-1:0] idx);
        logic [8*MSG_MAX-1:0] txt;
        logic [7:0]           asc;
        logic [CHAR_W-1:0]    ch;
        case (id)
            2'd0:    txt = MSG_TXT0;
            2'd1:    txt = MSG_TXT1;
            2'd2:    txt = MSG_TXT2;
            default: txt = MSG_TXT3;
        endcase
        txt = txt << (8 * idx);
        asc = txt[8*MSG_MAX-1 -: 8];
        ch  = CH_BLANK;
        if (asc >= 8'h41 && asc <= 8'h5A) ch = CHAR_W'(asc - 8'h40);
        return ch;
    endfunction

endpackage

// File: rtl/scroll_msg_arbiter_rom.sv
// Combinational message ROM: (id, idx) -> char code, (id) -> clamped length.
module msg_char_rom
    import scroll_msg_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic [MSG_ID_W-1:0]  id_i,
    input  logic [MSG_IDX_W-1:0] idx_i,
    output logic [CHAR_W-1:0]    char_o,
    output logic [LEN_W-1:0]     len_o
);

    // Table lookup with the length clamped so the sequencer never runs past MAX_LEN.
    always_comb begin
        int raw;
        raw    = msg_len(id_i);
        char_o = msg_char(id_i, idx_i);
        len_o  = LEN_W'((raw > MAX_LEN) ? MAX_LEN : raw);
    end

endmodule

// File: rtl/scroll_msg_arbiter.sv
// Round-robin owner of the scrolling display window; sequences one message per grant.
//  state    | meaning
//  ST_IDLE  | no owner, waiting for any request
//  ST_LOAD  | owner granted, message length latched
//  ST_SHIFT | message chars shifted in, one per step_en
//  ST_PAD   | blank chars shifted in after each pass
//  ST_DONE  | one-cycle completion pulse, owner still granted
module scroll_msg_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int CHAR_W    = 5,
    parameter int WIN_CHARS = 8,
    parameter int MAX_LEN   = 16,
    parameter int PAD_LEN   = 6,
    parameter int REPEATS   = 1
) (
    input  logic                        sec_clock,
    input  logic                        rst,
    input  logic                        step_en,
    input  logic [NUM_REQ-1:0]          req,
    output logic [NUM_REQ-1:0]          grant,
    output logic                        busy,
    output logic                        done,
    output logic [WIN_CHARS*CHAR_W-1:0] window
);
    import scroll_msg_pkg::*;

    localparam int WIN_W  = WIN_CHARS * CHAR_W;
    localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int IDX_W  = $clog2(MAX_LEN);
    localparam int LEN_W  = $clog2(MAX_LEN + 1);
    localparam int PAD_W  = $clog2(PAD_LEN + 1);
    localparam int PASS_W = $clog2(REPEATS + 1);

    state_e              state_q, state_d;
    logic [ID_W-1:0]     winner_q, winner_d, rr_q, rr_d, pick, next_rr;
    logic [LEN_W-1:0]    len_q, len_d, rom_len;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [PAD_W-1:0]    pad_q, pad_d;
    logic [PASS_W-1:0]   pass_q, pass_d;
    logic [WIN_W-1:0]    win_q, win_d;
    logic [CHAR_W-1:0]   rom_char;
    logic                abort, last_char, last_pad, more_pass;

    msg_char_rom #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_rom (
        .id_i   (MSG_ID_W'(winner_q)),
        .idx_i  (MSG_IDX_W'(idx_q)),
        .char_o (rom_char),
        .len_o  (rom_len)
    );

    assign abort     = !req[winner_q];
    assign last_char = (LEN_W'(idx_q) + LEN_W'(1)) == len_q;
    assign last_pad  = pad_q == PAD_W'(PAD_LEN - 1);
    assign more_pass = (int'(pass_q) + 1) < REPEATS;
    assign next_rr   = ID_W'((int'(winner_q) + 1) % NUM_REQ);

    // First set request at or above rr_q, wrapping around.
    always_comb begin
        int  c;
        logic found;
        c     = 0;
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            c = (int'(rr_q) + k) % NUM_REQ;
            if (!found && req[c]) begin
                found = 1'b1;
                pick  = ID_W'(c);
            end
        end
    end

    // State register.
    always_ff @(posedge sec_clock or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic; abort wins over a simultaneous step.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (|req) state_d = ST_LOAD;
            ST_LOAD:  state_d = (rom_len == '0) ? ST_PAD : ST_SHIFT;
            ST_SHIFT: begin
                if (abort)                       state_d = ST_IDLE;
                else if (step_en && last_char)   state_d = ST_PAD;
            end
            ST_PAD: begin
                if (abort) state_d = ST_IDLE;
                else if (step_en && last_pad) begin
                    if (!more_pass)         state_d = ST_DONE;
                    else if (len_q == '0)   state_d = ST_PAD;
                    else                    state_d = ST_SHIFT;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        grant = '0;
        if (state_q != ST_IDLE) grant[winner_q] = 1'b1;
        busy = (state_q != ST_IDLE);
        done = (state_q == ST_DONE);
    end

    // Datapath next values: counters, round-robin pointer and the shift window.
    always_comb begin
        winner_d = winner_q;
        rr_d     = rr_q;
        len_d    = len_q;
        idx_d    = idx_q;
        pad_d    = pad_q;
        pass_d   = pass_q;
        win_d    = win_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    winner_d = pick;
                    idx_d    = '0;
                    pad_d    = '0;
                    pass_d   = '0;
                    win_d    = '0;
                end
            end
            ST_LOAD: len_d = rom_len;
            ST_SHIFT: begin
                if (abort) begin
                    win_d = '0;
                    rr_d  = next_rr;
                end else if (step_en) begin
                    win_d = {win_q[WIN_W-CHAR_W-1:0], rom_char};
                    if (last_char) pad_d = '0;
                    else           idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_PAD: begin
                if (abort) begin
                    win_d = '0;
                    rr_d  = next_rr;
                end else if (step_en) begin
                    win_d = {win_q[WIN_W-CHAR_W-1:0], {CHAR_W{1'b0}}};
                    if (last_pad) begin
                        pad_d  = '0;
                        idx_d  = '0;
                        pass_d = pass_q + PASS_W'(1);
                    end else begin
                        pad_d = pad_q + PAD_W'(1);
                    end
                end
            end
            ST_DONE: rr_d = next_rr;
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge sec_clock or negedge rst) begin
        if (!rst) begin
            winner_q <= '0;
            rr_q     <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            pad_q    <= '0;
            pass_q   <= '0;
            win_q    <= '0;
        end else begin
            winner_q <= winner_d;
            rr_q     <= rr_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            pad_q    <= pad_d;
            pass_q   <= pass_d;
            win_q    <= win_d;
        end
    end

    assign window = win_q;

endmodule
